// File: rtl/decoder3_8_pulse.sv
// decoder3_8_pulse: queued 3-to-8 decoder emitting timed one-hot pulses separated by gaps
module decoder3_8_pulse #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_code,
  output logic [7:0] out,
  output logic       done,
  output logic       busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;
  localparam logic [7:0] PL1   = 8'(PULSE_LEN - 1);
  localparam logic [7:0] GL1   = 8'(GAP_LEN > 0 ? GAP_LEN - 1 : 0);
  logic [1:0] state_q, state_d, occ_q, occ_d;
  logic [7:0] cnt_q, cnt_d, out_q, out_d;
  logic [2:0] f0_q, f0_d, f1_q, f1_d;
  logic       push, pop, ld;
  assign in_ready = (occ_q != 2'd2) && !rst;
  assign push     = in_valid && in_ready;
  assign done     = (state_q == PULSE) && (cnt_q == 8'd0);
  assign busy     = (state_q != IDLE) || (occ_q != 2'd0);
  assign out      = out_q;
  // pulse/gap sequencing; ld pops the head code and starts its pulse
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    ld      = 1'b0;
    case (state_q)
      IDLE: begin
        out_d = 8'd0;
        ld    = occ_q != 2'd0;
      end
      PULSE: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else if (GAP_LEN > 0) begin
          out_d   = 8'd0;
          cnt_d   = GL1;
          state_d = GAP;
        end else if (occ_q != 2'd0) ld = 1'b1;
        else begin
          out_d   = 8'd0;
          state_d = IDLE;
        end
      end
      GAP: begin
        out_d = 8'd0;
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else if (occ_q != 2'd0) ld = 1'b1;
        else state_d = IDLE;
      end
      default: begin
        out_d   = 8'd0;
        state_d = IDLE;
      end
    endcase
    pop = ld;
    if (ld) begin
      out_d   = 8'b1 << f0_q;
      cnt_d   = PL1;
      state_d = PULSE;
    end
  end
  // two-entry shift FIFO: f0 is the head; pop shifts before push lands
  always_comb begin
    f0_d  = f0_q;
    f1_d  = f1_q;
    occ_d = occ_q;
    if (pop) begin
      f0_d  = f1_q;
      occ_d = occ_q - 2'd1;
    end
    if (push) begin
      if (occ_d == 2'd0) f0_d = in_code;
      else f1_d = in_code;
      occ_d = occ_d + 2'd1;
    end
  end
  // state registers, cleared asynchronously so reset drops out immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      out_q   <= 8'd0;
      occ_q   <= 2'd0;
      f0_q    <= 3'd0;
      f1_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      occ_q   <= occ_d;
      f0_q    <= f0_d;
      f1_q    <= f1_d;
    end
  end
endmodule

// File: tb/tb_decoder3_8_pulse.sv
// tb_decoder3_8_pulse: directed checks of three parameterisations of decoder3_8_pulse
module tb_decoder3_8_pulse;
  logic clk = 1'b0, rst = 1'b1;
  logic va = 1'b0, vb = 1'b0, vc = 1'b0;
  logic [2:0] ca = 3'd0, cb = 3'd0, cc = 3'd0;
  logic ra, rb, rc, da, db, dc, ba, bb, bc;
  logic [7:0] oa, ob, oc;
  int vecs = 0, fails = 0;
  always #5 clk = ~clk;
  decoder3_8_pulse #(.PULSE_LEN(4), .GAP_LEN(1)) ua (.clk(clk), .rst(rst), .in_valid(va), .in_ready(ra), .in_code(ca), .out(oa), .done(da), .busy(ba));
  decoder3_8_pulse #(.PULSE_LEN(3), .GAP_LEN(0)) ub (.clk(clk), .rst(rst), .in_valid(vb), .in_ready(rb), .in_code(cb), .out(ob), .done(db), .busy(bb));
  decoder3_8_pulse #(.PULSE_LEN(1), .GAP_LEN(0)) uc (.clk(clk), .rst(rst), .in_valid(vc), .in_ready(rc), .in_code(cc), .out(oc), .done(dc), .busy(bc));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      va = 1'($urandom); vb = 1'($urandom); vc = 1'($urandom);
      ca = 3'($urandom); cb = 3'($urandom); cc = 3'($urandom);
      tick;
      vecs++;
      if ({oa, ob, oc, da, db, dc, ba, bb, bc, ra, rb, rc} !== 36'd0) begin
        fails++;
        $display("FAIL reset_hold cyc %0d: got out %h/%h/%h flags %b want all zero", i, oa, ob, oc, {da, db, dc, ba, bb, bc, ra, rb, rc});
      end
    end
    va = 1'b0; vb = 1'b0; vc = 1'b0;
    rst = 1'b0;
    #1;
    vecs++;
    if ({ra, rb, rc, ba, bb, bc} !== 6'b111000) begin
      fails++;
      $display("FAIL reset_release: ready %b busy %b want 111 000", {ra, rb, rc}, {ba, bb, bc});
    end
  endtask
  task automatic test_single;
    va = 1'b1; ca = 3'd5;
    tick;
    va = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      logic [7:0] eo;
      logic ed, eb;
      tick;
      eo = (k <= 4) ? 8'h20 : 8'h00;
      ed = k == 4;
      eb = k <= 5;
      vecs++;
      if (oa !== eo || da !== ed || ba !== eb) begin
        fails++;
        $display("FAIL single cyc %0d: got out %h done %b busy %b want %h %b %b", k, oa, da, ba, eo, ed, eb);
      end
    end
  endtask
  task automatic test_backlog;
    logic [2:0] seq [4] = '{3'd0, 3'd7, 3'd2, 3'd4};
    int want [4] = '{0, 1, 2, 7};
    int got [4] = '{-1, -1, -1, -1};
    int n = 0;
    va = 1'b1; ca = seq[0];
    for (int k = 0; k <= 21; k++) begin
      logic acc;
      logic [7:0] eo;
      logic ed;
      acc = va && ra;
      tick;
      if (acc) begin
        got[n] = k;
        n++;
        if (n < 4) ca = seq[n];
        else va = 1'b0;
      end
      eo = (k % 5 == 0 || k > 20) ? 8'h00 : 8'b1 << seq[(k - 1) / 5];
      ed = (k % 5 == 4) && k < 20;
      vecs++;
      if (oa !== eo || da !== ed) begin
        fails++;
        $display("FAIL backlog cyc %0d: got out %h done %b want %h %b", k, oa, da, eo, ed);
      end
      if (k == 2) begin
        vecs++;
        if (ra !== 1'b0) begin
          fails++;
          $display("FAIL backlog_full: in_ready %b want 0", ra);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      vecs++;
      if (got[i] !== want[i]) begin
        fails++;
        $display("FAIL backlog_accept %0d: edge %0d want %0d", i, got[i], want[i]);
      end
    end
    vecs++;
    if (ba !== 1'b0) begin
      fails++;
      $display("FAIL backlog_idle: busy %b want 0", ba);
    end
  endtask
  task automatic test_gap0;
    vb = 1'b1; cb = 3'd1;
    tick;
    tick;
    vb = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      logic [7:0] eo;
      logic ed, eb;
      eo = (k <= 6) ? 8'h02 : 8'h00;
      ed = k == 3 || k == 6;
      eb = k <= 6;
      vecs++;
      if (ob !== eo || db !== ed || bb !== eb) begin
        fails++;
        $display("FAIL gap0 cyc %0d: got out %h done %b busy %b want %h %b %b", k, ob, db, bb, eo, ed, eb);
      end
      tick;
    end
  endtask
  task automatic test_walk;
    for (int i = 0; i <= 9; i++) begin
      logic [7:0] eo;
      logic ed;
      if (i < 8) begin
        vc = 1'b1;
        cc = 3'(i);
      end else vc = 1'b0;
      tick;
      ed = i >= 1 && i <= 8;
      eo = ed ? 8'b1 << (i - 1) : 8'h00;
      vecs++;
      if (oc !== eo || dc !== ed) begin
        fails++;
        $display("FAIL walk cyc %0d: got out %h done %b want %h %b", i, oc, dc, eo, ed);
      end
    end
  endtask
  task automatic test_mid_reset;
    va = 1'b1; ca = 3'd3;
    tick;
    ca = 3'd1;
    tick;
    ca = 3'd6;
    tick;
    va = 1'b0;
    vecs++;
    if (oa !== 8'h08 || ra !== 1'b0) begin
      fails++;
      $display("FAIL midrst_setup: out %h ready %b want 08 0", oa, ra);
    end
    #1 rst = 1'b1;
    #1;
    vecs++;
    if (oa !== 8'h00 || da !== 1'b0 || ba !== 1'b0 || ra !== 1'b0) begin
      fails++;
      $display("FAIL midrst_async: out %h done %b busy %b ready %b want 00 0 0 0", oa, da, ba, ra);
    end
    tick;
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick;
      vecs++;
      if (oa !== 8'h00 || ba !== 1'b0) begin
        fails++;
        $display("FAIL midrst_after cyc %0d: out %h busy %b want 00 0", k, oa, ba);
      end
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_backlog;
    test_gap0;
    test_walk;
    test_mid_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
